// File: rtl/nubus_block_master.sv
// rtl/nubus_block_master.sv - NuBus master engine for single-word and block transfers with retry replay
//
// Request side : req_valid/req_ready/req_addr/req_write/req_len/req_lock accept one transfer.
//                wr_valid/wr_ready/wr_data fill the block buffer for writes.
//                rd_valid/rd_ready/rd_data drain the block buffer after a good read.
//                done pulses once per transfer; status holds the outcome until the next done.
// Bus side     : arb_grant, bus_busy, bus_ack, bus_tm, bus_ad are sampled bus values.
//                rqst_o, start_o, ad_o/ad_oe, tm_o/tm_oe feed the top-level tristate drivers.
// Clock/reset  : nub_clk rising edge; nub_reset asynchronous active-high.

module nubus_block_master #(
    parameter int MAX_BLOCK_LOG2 = 4,
    parameter int WDT_W          = 8,
    parameter int RETRY_MAX      = 3,
    parameter int BACKOFF_W      = 4
) (
    input  logic        nub_clk,
    input  logic        nub_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [2:0]  req_len,
    input  logic        req_lock,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        done,
    output logic [1:0]  status,
    input  logic        arb_grant,
    input  logic        bus_busy,
    input  logic        bus_ack,
    input  logic [1:0]  bus_tm,
    input  logic [31:0] bus_ad,
    output logic        rqst_o,
    output logic        start_o,
    output logic [31:0] ad_o,
    output logic        ad_oe,
    output logic [1:0]  tm_o,
    output logic        tm_oe
);

    localparam int DEPTH = 1 << MAX_BLOCK_LOG2;
    localparam int BW    = MAX_BLOCK_LOG2;
    localparam int RW    = $clog2(RETRY_MAX + 2);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERROR   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_RETRY   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARB, S_ADDR, S_DATA, S_BACKOFF, S_DRAIN
    } state_t;

    state_t              state_q, state_n;
    logic [31:2]         addr_q;
    logic                write_q;
    logic [2:0]          len_q;
    logic                lock_q;
    logic [BW-1:0]       beat_q, beat_n;
    logic [WDT_W-1:0]    wdt_q, wdt_n;
    logic [RW-1:0]       retry_q, retry_n;
    logic [BACKOFF_W-1:0] bo_q, bo_n;
    logic                done_q, done_n;
    logic [1:0]          status_q, status_n;
    logic                accept;
    logic                buf_we;
    logic [31:0]         buf_wdata;
    logic [31:0]         buf_mem [DEPTH];
    logic [BW-1:0]       last_idx;
    logic                is_last;
    logic [31:0]         addr_word;
    logic                unused_addr_bits;

    // Byte-lane bits never reach the bus; the address phase always drives 00 there.
    assign unused_addr_bits = ^req_addr[1:0];

    assign last_idx = BW'((32'd1 << len_q) - 32'd1);
    assign is_last  = (beat_q == last_idx);
    assign done     = done_q;
    assign status   = status_q;

    // Block transfers encode the size in the low address bits: a single 1 at
    // position len-1 within the len-bit field starting at bit 2.
    always_comb begin
        addr_word = {addr_q, 2'b00};
        if (len_q != 3'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(len_q)) begin
                    addr_word[i+2] = (i == int'(len_q) - 1);
                end
            end
        end
    end

    always_comb begin
        state_n   = state_q;
        beat_n    = beat_q;
        wdt_n     = wdt_q;
        retry_n   = retry_q;
        bo_n      = bo_q;
        done_n    = 1'b0;
        status_n  = status_q;
        accept    = 1'b0;
        buf_we    = 1'b0;
        buf_wdata = bus_ad;
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = 32'd0;
        rqst_o    = 1'b0;
        start_o   = 1'b0;
        ad_o      = 32'd0;
        ad_oe     = 1'b0;
        tm_o      = 2'b00;
        tm_oe     = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    beat_n  = '0;
                    retry_n = '0;
                    if (int'(req_len) > MAX_BLOCK_LOG2) begin
                        done_n   = 1'b1;
                        status_n = ST_ERROR;
                    end else if (req_write) begin
                        state_n = S_LOAD;
                    end else begin
                        state_n = S_ARB;
                    end
                end
            end
            S_LOAD: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    buf_we    = 1'b1;
                    buf_wdata = wr_data;
                    if (is_last) begin
                        beat_n  = '0;
                        state_n = S_ARB;
                    end else begin
                        beat_n = beat_q + BW'(1);
                    end
                end
            end
            S_ARB: begin
                rqst_o = 1'b1;
                if (arb_grant && !bus_busy) begin
                    state_n = S_ADDR;
                end
            end
            S_ADDR: begin
                rqst_o  = lock_q;
                start_o = 1'b1;
                ad_oe   = 1'b1;
                ad_o    = addr_word;
                tm_oe   = 1'b1;
                tm_o    = {write_q, 1'b1};
                beat_n  = '0;
                wdt_n   = '0;
                state_n = S_DATA;
            end
            S_DATA: begin
                rqst_o = lock_q;
                ad_oe  = write_q;
                ad_o   = write_q ? buf_mem[beat_q] : 32'd0;
                if (bus_ack) begin
                    state_n = S_IDLE;
                    case (bus_tm)
                        2'b00: begin
                            if (!is_last) begin
                                done_n   = 1'b1;
                                status_n = ST_ERROR;
                            end else if (write_q) begin
                                done_n   = 1'b1;
                                status_n = ST_OK;
                            end else begin
                                buf_we  = 1'b1;
                                beat_n  = '0;
                                state_n = S_DRAIN;
                            end
                        end
                        2'b01: begin
                            done_n   = 1'b1;
                            status_n = ST_ERROR;
                        end
                        2'b10: begin
                            done_n   = 1'b1;
                            status_n = ST_TIMEOUT;
                        end
                        default: begin
                            retry_n = retry_q + RW'(1);
                            if (int'(retry_q) + 1 <= RETRY_MAX) begin
                                bo_n    = '0;
                                state_n = S_BACKOFF;
                            end else begin
                                done_n   = 1'b1;
                                status_n = ST_RETRY;
                            end
                        end
                    endcase
                end else if (bus_tm[0] && !is_last) begin
                    // Intermediate ack: an ack on the last beat must be final, so it is ignored there.
                    buf_we = !write_q;
                    beat_n = beat_q + BW'(1);
                    wdt_n  = '0;
                end else if (wdt_q == {WDT_W{1'b1}}) begin
                    done_n   = 1'b1;
                    status_n = ST_TIMEOUT;
                    state_n  = S_IDLE;
                end else begin
                    wdt_n = wdt_q + WDT_W'(1);
                end
            end
            S_BACKOFF: begin
                rqst_o = lock_q;
                if (bo_q == {BACKOFF_W{1'b1}}) begin
                    beat_n  = '0;
                    state_n = S_ARB;
                end else begin
                    bo_n = bo_q + BACKOFF_W'(1);
                end
            end
            S_DRAIN: begin
                rd_valid = 1'b1;
                rd_data  = buf_mem[beat_q];
                if (rd_ready) begin
                    if (is_last) begin
                        done_n   = 1'b1;
                        status_n = ST_OK;
                        state_n  = S_IDLE;
                    end else begin
                        beat_n = beat_q + BW'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            len_q    <= 3'd0;
            lock_q   <= 1'b0;
            beat_q   <= '0;
            wdt_q    <= '0;
            retry_q  <= '0;
            bo_q     <= '0;
            done_q   <= 1'b0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_n;
            beat_q   <= beat_n;
            wdt_q    <= wdt_n;
            retry_q  <= retry_n;
            bo_q     <= bo_n;
            done_q   <= done_n;
            status_q <= status_n;
            if (accept) begin
                addr_q  <= req_addr[31:2];
                write_q <= req_write;
                len_q   <= req_len;
                lock_q  <= req_lock;
            end
        end
    end

    // Buffer contents need no reset; they are always written before being driven out.
    always_ff @(posedge nub_clk) begin
        if (buf_we) begin
            buf_mem[beat_q] <= buf_wdata;
        end
    end

endmodule

// File: doc/nubus_block_master.md
Name: nubus_block_master

Overview:
- Parametrised NuBus master engine, successor to the single-word master path inside the NuBus controller.
- Executes single-word and NuBus block transfers (2/4/8/16 words) on behalf of the card CPU/DMA.
- Buffers a whole block so that try-again-later responses are replayed automatically with bounded retries, backoff and a per-beat watchdog.
- Sits between the CPU/DMA request side and the top-level tristate drivers; all bus-side ports are active-high (inversion and tristating are done in the top).

Parameters:
- MAX_BLOCK_LOG2, 4, largest block is 2^MAX_BLOCK_LOG2 words (1..4); also sets the buffer depth.
- WDT_W, 8, watchdog width; a beat times out after 2^WDT_W cycles without acknowledge.
- RETRY_MAX, 3, number of try-again replays before giving up.
- BACKOFF_W, 4, backoff counter width; wait is 2^BACKOFF_W cycles between retries.

Ports:
- nub_clk  in  1  NuBus sampling clock (rising edge; the top inverts nub_clkn).
- nub_reset  in  1  asynchronous active-high reset.
- req_valid  in  1  transfer request.
- req_ready  out  1  engine idle, request accepted when req_valid & req_ready.
- req_addr  in  32  byte address.
- req_write  in  1  1 = write.
- req_len  in  3  log2 of word count (0 = single word).
- req_lock  in  1  hold bus request for the whole transfer including retries.
- wr_valid  in  1  write word available.
- wr_ready  out  1  write word taken.
- wr_data  in  32  write word.
- rd_valid  out  1  read word available.
- rd_ready  in  1  read word taken.
- rd_data  out  32  read word.
- done  out  1  one-cycle completion pulse.
- status  out  2  00 complete, 01 error, 10 timeout, 11 try-again exhausted; valid with done, held until next done.
- arb_grant  in  1  arbiter won.
- bus_busy  in  1  another transaction is in progress.
- bus_ack  in  1  sampled ACK.
- bus_tm  in  2  sampled {TM1,TM0}.
- bus_ad  in  32  sampled AD.
- rqst_o  out  1  drive RQST.
- start_o  out  1  drive START.
- ad_o  out  32  AD value.
- ad_oe  out  1  drive AD.
- tm_o  out  2  TM value.
- tm_oe  out  1  drive TM.

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready = 1; counters and buffer pointers cleared.
- Reset mid-transfer drops all bus drives in the same cycle (asynchronous); no done pulse.
- States: IDLE, LOAD, ARB, ADDR, DATA, BACKOFF, DRAIN.
- IDLE:
  - Accepting a request latches addr, write, len and lock.
  - If req_len > MAX_BLOCK_LOG2: done next cycle, status 01, no bus activity.
  - Otherwise a write goes to LOAD and a read goes to ARB.
- LOAD:
  - wr_ready = 1; the buffer is filled on each wr_valid & wr_ready.
  - After 2^len words go to ARB.
- ARB:
  - rqst_o = 1.
  - Go to ADDR when arb_grant & ~bus_busy, sampled the same edge.
- ADDR (exactly one cycle):
  - start_o = 1, ad_oe = 1, tm_oe = 1, tm_o = {write, 1}.
  - ad_o[31:6] = addr[31:6]; ad_o[1:0] = 00.
  - Single word (len 0): ad_o[5:2] = addr[5:2].
  - Block (len n ≥ 1): ad_o[1+n:2] = 1 << (n-1); bits above come from addr.
  - rqst_o drops unless lock is set.
  - Beat index and watchdog cleared.
- DATA:
  - Writes: ad_oe = 1, ad_o = buffer[beat].
  - Reads: ad_oe = 0. tm_oe = 0 in both cases.
  - Intermediate ack (~bus_ack & bus_tm[0]) on a beat before the last: a read stores bus_ad; beat++; watchdog cleared. On the last beat it is ignored.
  - Final ack (bus_ack) with bus_tm = 00 on the last beat: a read stores bus_ad, then go to DRAIN; a write does done, status 00, then IDLE.
  - Final ack 00 before the last beat: done, status 01.
  - bus_tm = 01: done, status 01.
  - bus_tm = 10: done, status 10.
  - bus_tm = 11: retry++; if retry ≤ RETRY_MAX go to BACKOFF, else done, status 11.
  - Watchdog reaching 2^WDT_W-1 without an ack: release all drives, done, status 10.
  - Ack and watchdog expiry on the same edge: the ack wins.
- BACKOFF:
  - Count 2^BACKOFF_W cycles, then ARB; beat resets to 0.
  - The write buffer is replayed unchanged; read words already stored are overwritten.
- DRAIN:
  - rd_valid = 1 with buffer words in order, advancing on rd_ready.
  - After the last word: done, status 00, then IDLE.
  - Read data is never presented on error, timeout or exhausted retry.
- req_ready = 1 only in IDLE.
- done is registered and asserted the cycle after the terminating event.

Test Plan:
- Single read, addr 0xF3000010; slave final ack tm=00 with ad 0xDEADBEEF at 3rd DATA cycle -> ADDR cycle ad_o=0xF3000010, tm_o=01; one rd_valid word 0xDEADBEEF; done with status 00.
- Write block len=2, words 1,2,3,4, addr 0xF3000100; slave gives intermediates on beats 0–2 then final 00 -> ad_o[5:2]=0010 at ADDR; ad_o sequence 1,2,3,4; done status 00 after final ack.
- Read len=3; first attempt final tm=11; second attempt completes 8 words -> one backoff of 16 cycles, rqst_o reasserted; rd_valid delivers only the 8 words of attempt 2; status 00.
- Try-again on every attempt, RETRY_MAX=3 -> exactly 4 ADDR cycles; done status 11; no rd_valid.
- No ack after ADDR, WDT_W=8 -> done status 10 at 256 cycles after ADDR; ad_oe, tm_oe and start_o are 0 from then on.
- req_len=5 -> done status 01, rqst_o never asserted.
- Separate case: assert nub_reset mid-DATA -> all drives 0 immediately and req_ready=1.
